prog_mem_arbiter: RTL and testbench
===================================

PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word address width; depth is 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width, a multiple of 8; BE_W = DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_CH, default 2: number of CPU channels, legal range 1..8.
REQ-004 SHALL have port clk  input  1  as its single clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  as its reset, asynchronous and active-low.
REQ-006 SHALL have port dbg_en  input  1  as the debug/programming mode enable.
REQ-007 SHALL have ports dbg_req, dbg_we  input  1 each  as the debug request and write select.
REQ-008 SHALL have ports dbg_addr  input  ADDR_WIDTH  and dbg_wdata  input  DATA_WIDTH  as the debug address and write data.
REQ-009 SHALL have ports dbg_ack  output  1  and dbg_rdata  output  DATA_WIDTH  as the debug completion pulse and read data.
REQ-010 SHALL have ports ch_req, ch_we  input  NUM_CH each  as the per-channel request and write select.
REQ-011 SHALL have ports ch_addr  input  NUM_CH*ADDR_WIDTH, ch_wdata  input  NUM_CH*DATA_WIDTH, and ch_be  input  NUM_CH*BE_W, with channel i in slice i.
REQ-012 SHALL have ports ch_ack  output  NUM_CH  and ch_rdata  output  DATA_WIDTH  as the per-channel completion pulse and shared read data.
REQ-013 SHALL have port cpu_hold  output  1, asserted while debug mode owns the memory.

Function
REQ-014 SHALL contain a single-port memory array of 2**ADDR_WIDTH x DATA_WIDTH with at most one access per cycle.
REQ-015 SHALL grant the debug requester when dbg_en=1 and dbg_req=1; no CPU channel is granted in any cycle while dbg_en=1.
REQ-016 SHALL arbitrate CPU channels round-robin when dbg_en=0: search from pointer rr_ptr upward and wrap from NUM_CH-1 to 0.
REQ-017 SHALL set rr_ptr to (i+1) mod NUM_CH after granting channel i; debug grants leave rr_ptr unchanged.
REQ-018 SHALL exclude from arbitration any requester whose ack is asserted in the current cycle, so a held req is not re-granted.
REQ-019 SHALL perform the granted access at the end of grant cycle N: write applies ch_be per byte (debug writes all bytes); read captures the addressed word.
REQ-020 SHALL pulse the granted requester's ack for exactly one cycle in cycle N+1; for reads, rdata is valid only in that cycle.
REQ-021 SHALL hold dbg_rdata/ch_rdata at their last value when ack is not asserted, and leave them unchanged on write acks.
REQ-022 SHALL have throughput of one grant per cycle aggregate and one transaction per 2 cycles per requester.
REQ-023 SHALL require requesters to hold req, we, addr, wdata, and be stable until ack; in the ack cycle they may drop req or present a new transaction.
REQ-024 SHALL, for a read following a write to the same address in the next grant, return the newly written data.
REQ-025 SHALL still complete and ack an access granted in the same cycle dbg_en rises; later CPU requests stall until dbg_en=0.
REQ-026 SHALL set cpu_hold to the value of dbg_en registered one cycle earlier, and keep it at 1 until the last debug ack has issued.
REQ-027 SHALL treat dbg_req while dbg_en=0 as ignored, with no ack.

Reset
REQ-028 SHALL, while rst_n=0, force dbg_ack=0, ch_ack=0, cpu_hold=0, dbg_rdata=0, ch_rdata=0, rr_ptr=0, and clear the pending-ack state.
REQ-029 SHALL, on reset asserted mid-transaction, drop the pending ack with no ack pulse after release; the state of a write in its grant cycle is undefined.
REQ-030 SHALL not initialise memory contents on reset.

Verification
REQ-031 SHALL cover debug programming: dbg_en=1, write 0xDEADBEEF @0x010, read @0x010 -> dbg_ack at N+1 each, dbg_rdata=0xDEADBEEF, cpu_hold=1.
REQ-032 SHALL cover round-robin fairness: NUM_CH=2, both ch_req held for 8 cycles -> grants alternate 0,1,0,1, 4 acks per channel, no back-to-back ack to the same channel.
REQ-033 SHALL cover debug pre-emption: ch0 streaming reads, raise dbg_en -> in-flight ch0 ack completes, no further ch_ack, dbg accesses serviced; drop dbg_en -> ch0 resumes, cpu_hold falls one cycle later.
REQ-034 SHALL cover byte enables: write 0xFFFFFFFF @5, then ch1 write 0x12345678 be=0b0101 @5, read @5 -> 0xFF34FF78.
REQ-035 SHALL cover reset mid-op: assert rst_n=0 in grant cycle of a read -> no ack after release, all outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: single-port program memory shared by a debug port and round-robin CPU channels
module prog_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             dbg_en,
    input  logic                             dbg_req,
    input  logic                             dbg_we,
    input  logic [ADDR_WIDTH-1:0]            dbg_addr,
    input  logic [DATA_WIDTH-1:0]            dbg_wdata,
    output logic                             dbg_ack,
    output logic [DATA_WIDTH-1:0]            dbg_rdata,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0]                ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_be,
    output logic [NUM_CH-1:0]                ch_ack,
    output logic [DATA_WIDTH-1:0]            ch_rdata,
    output logic                             cpu_hold
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_CH-1:0]     el;
    logic [NUM_CH-1:0]     el_hi;
    logic [NUM_CH-1:0]     sel;
    logic [NUM_CH-1:0]     gnt_oh;
    logic                  dbg_go;
    logic                  cpu_go;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [BE_W-1:0]       acc_be;

    // Pick this cycle's single access: debug owns the array while dbg_en is high, otherwise
    // the first eligible channel at or above rr_ptr wins, wrapping to the lowest eligible one.
    // A requester already being acked this cycle is skipped so its held req is not re-served.
    always_comb begin
        dbg_go  = dbg_en & dbg_req & ~dbg_ack;
        el      = ch_req & ~ch_ack & {NUM_CH{~dbg_en}};
        el_hi   = '0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int i = 0; i < NUM_CH; i++)
            el_hi[i] = el[i] && (i >= int'(rr_ptr));
        sel    = (|el_hi) ? el_hi : el;
        cpu_go = |el;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (sel[i]) gnt_idx = PW'(i);
        for (int i = 0; i < NUM_CH; i++)
            gnt_oh[i] = cpu_go && (gnt_idx == PW'(i));
        acc_we    = dbg_we;
        acc_addr  = dbg_addr;
        acc_wdata = dbg_wdata;
        acc_be    = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) begin
                acc_we    = ch_we[i];
                acc_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                acc_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                acc_be    = ch_be[i*BE_W +: BE_W];
            end
        end
    end

    // Byte-masked write into the array at the end of the grant cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if ((dbg_go || cpu_go) && acc_we)
            for (int b = 0; b < BE_W; b++)
                if (acc_be[b]) mem[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
    end

    // One-cycle acks, read capture, rotation pointer and registered debug-hold flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ack   <= 1'b0;
            ch_ack    <= '0;
            cpu_hold  <= 1'b0;
            dbg_rdata <= '0;
            ch_rdata  <= '0;
            rr_ptr    <= '0;
        end else begin
            dbg_ack  <= dbg_go;
            ch_ack   <= gnt_oh;
            cpu_hold <= dbg_en;
            if (dbg_go && !dbg_we) dbg_rdata <= mem[dbg_addr];
            if (cpu_go && !acc_we) ch_rdata <= mem[acc_addr];
            if (cpu_go) rr_ptr <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb_prog_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_prog_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dbg_en = 1'b0;
    logic            dbg_req = 1'b0;
    logic            dbg_we = 1'b0;
    logic [AW-1:0]   dbg_addr = '0;
    logic [DW-1:0]   dbg_wdata = '0;
    logic            dbg_ack;
    logic [DW-1:0]   dbg_rdata;
    logic [NC-1:0]   ch_req = '0;
    logic [NC-1:0]   ch_we = '0;
    logic [NC*AW-1:0] ch_addr = '0;
    logic [NC*DW-1:0] ch_wdata = '0;
    logic [NC*4-1:0] ch_be = '0;
    logic [NC-1:0]   ch_ack;
    logic [DW-1:0]   ch_rdata;
    logic            cpu_hold;

    int checks = 0;
    int failures = 0;

    prog_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .dbg_en(dbg_en), .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
        .ch_ack(ch_ack), .ch_rdata(ch_rdata), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; lat = 0;
        do begin tick(); lat++; end while (!dbg_ack && lat < 20);
        dbg_req = 1'b0;
    endtask

    task automatic ch_op(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] be, output int lat);
        ch_we[c] = we; ch_addr[c*AW +: AW] = a; ch_wdata[c*DW +: DW] = d; ch_be[c*4 +: 4] = be;
        ch_req[c] = 1'b1; lat = 0;
        do begin tick(); lat++; end while (!ch_ack[c] && lat < 20);
        ch_req[c] = 1'b0;
    endtask

    task automatic test_reset;
        dbg_en = 1'b1;
        repeat (3) tick();
        checks++;
        if ({dbg_ack, ch_ack, cpu_hold, dbg_rdata, ch_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b ch_ack=%b hold=%b drd=%h crd=%h want all 0",
                     dbg_ack, ch_ack, cpu_hold, dbg_rdata, ch_rdata);
        end
        dbg_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if ({dbg_ack, ch_ack, cpu_hold, dbg_rdata, ch_rdata} !== '0) begin
            failures++;
            $display("FAIL post_reset_outputs: got ack=%b ch_ack=%b hold=%b want 0", dbg_ack, ch_ack, cpu_hold);
        end
    endtask

    task automatic test_dbg_ignored;
        dbg_we = 1'b0; dbg_addr = 10'h3; dbg_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dbg_ack !== 1'b0) begin
                failures++;
                $display("FAIL dbg_ignored_%0d: dbg_ack got %b want 0", k, dbg_ack);
            end
        end
        dbg_req = 1'b0;
    endtask

    task automatic test_round_robin;
        int n0 = 0;
        int n1 = 0;
        logic [NC-1:0] exp;
        ch_we = '0; ch_addr = '0; ch_req = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) ch_req = '0;
            exp = (k % 2 == 1) ? 2'b01 : 2'b10;
            n0 += int'(ch_ack[0]);
            n1 += int'(ch_ack[1]);
            checks++;
            if (ch_ack !== exp) begin
                failures++;
                $display("FAIL rr_grant_%0d: ch_ack got %b want %b", k, ch_ack, exp);
            end
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin
            failures++;
            $display("FAIL rr_counts: got ch0=%0d ch1=%0d want 4 and 4", n0, n1);
        end
        tick();
    endtask

    task automatic test_debug_prog;
        int lat;
        dbg_en = 1'b1;
        tick();
        checks++;
        if (cpu_hold !== 1'b1) begin failures++; $display("FAIL dbg_hold: cpu_hold got %b want 1", cpu_hold); end
        dbg_op(1'b1, 10'h010, 32'hDEADBEEF, lat);
        checks++;
        if (lat != 1) begin failures++; $display("FAIL dbg_write_lat: got %0d want 1", lat); end
        dbg_op(1'b0, 10'h010, 32'h0, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL dbg_read_lat: got %0d want 2", lat); end
        checks++;
        if (dbg_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL dbg_read_data: got %h want deadbeef", dbg_rdata); end
        dbg_en = 1'b0;
        tick();
        checks++;
        if (cpu_hold !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL dbg_release: hold=%b ack=%b rdata=%h want 0 0 deadbeef", cpu_hold, dbg_ack, dbg_rdata);
        end
    endtask

    task automatic test_byte_enable;
        int lat;
        ch_op(0, 1'b1, 10'd5, 32'hFFFFFFFF, 4'hF, lat);
        checks++;
        if (lat != 1) begin failures++; $display("FAIL be_w0_lat: got %0d want 1", lat); end
        ch_op(1, 1'b1, 10'd5, 32'h12345678, 4'b0101, lat);
        checks++;
        if (lat != 1) begin failures++; $display("FAIL be_w1_lat: got %0d want 1", lat); end
        ch_op(0, 1'b0, 10'd5, 32'h0, 4'h0, lat);
        checks++;
        if (lat != 1 || ch_rdata !== 32'hFF34FF78) begin
            failures++;
            $display("FAIL be_read: lat=%0d data=%h want 1 ff34ff78", lat, ch_rdata);
        end
        tick();
    endtask

    task automatic test_preempt;
        int lat;
        ch_we[0] = 1'b0; ch_addr[0 +: AW] = 10'd5; ch_req[0] = 1'b1;
        tick();
        dbg_en = 1'b1;
        checks++;
        if (ch_ack !== 2'b01 || ch_rdata !== 32'hFF34FF78) begin
            failures++;
            $display("FAIL preempt_inflight: ch_ack=%b data=%h want 01 ff34ff78", ch_ack, ch_rdata);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ch_ack !== 2'b00 || cpu_hold !== 1'b1) begin
                failures++;
                $display("FAIL preempt_stall_%0d: ch_ack=%b hold=%b want 00 1", k, ch_ack, cpu_hold);
            end
        end
        dbg_op(1'b1, 10'd7, 32'hA5A5_0F0F, lat);
        dbg_op(1'b0, 10'd7, 32'h0, lat);
        checks++;
        if (lat != 2 || dbg_rdata !== 32'hA5A5_0F0F || ch_ack !== 2'b00) begin
            failures++;
            $display("FAIL preempt_dbg: lat=%0d data=%h ch_ack=%b want 2 a5a50f0f 00", lat, dbg_rdata, ch_ack);
        end
        dbg_en = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1) begin failures++; $display("FAIL preempt_hold_lag: got %b want 1", cpu_hold); end
        tick();
        checks++;
        if (ch_ack !== 2'b01 || cpu_hold !== 1'b0 || ch_rdata !== 32'hFF34FF78) begin
            failures++;
            $display("FAIL preempt_resume: ch_ack=%b hold=%b data=%h want 01 0 ff34ff78", ch_ack, cpu_hold, ch_rdata);
        end
        ch_req = '0;
        tick();
    endtask

    task automatic test_reset_midop;
        ch_we = '0; ch_addr[0 +: AW] = 10'd5; ch_req = 2'b01;
        #2;
        rst_n = 1'b0;
        ch_req = '0;
        #1;
        checks++;
        if ({dbg_ack, ch_ack, cpu_hold, dbg_rdata, ch_rdata} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs: ch_ack=%b crd=%h drd=%h want 0", ch_ack, ch_rdata, dbg_rdata);
        end
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ch_ack !== 2'b00 || dbg_ack !== 1'b0) begin
                failures++;
                $display("FAIL midop_no_ack_%0d: ch_ack=%b dbg_ack=%b want 00 0", k, ch_ack, dbg_ack);
            end
        end
        ch_req = 2'b11;
        tick();
        ch_req = '0;
        checks++;
        if (ch_ack !== 2'b01) begin failures++; $display("FAIL midop_rr_ptr: ch_ack got %b want 01", ch_ack); end
        tick();
    endtask

    task automatic test_random;
        logic [DW-1:0] shadow [16];
        logic [DW-1:0] exp_drd = '0;
        logic [DW-1:0] exp_crd = '0;
        logic          d_known = 1'b0;
        logic          c_known = 1'b0;
        logic          m_dack = 1'b0;
        logic [NC-1:0] m_cack = '0;
        logic [NC-1:0] exp_cack;
        logic          e_dbg;
        logic          exp_hold;
        logic [3:0]    a;
        int            mrr = 0;
        int            e_ch;
        int            lat;
        rst_n = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        dbg_en = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            dbg_op(1'b1, AW'(i), shadow[i], lat);
        end
        dbg_en = 1'b0;
        repeat (2) tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            e_dbg = dbg_en && dbg_req && !m_dack;
            e_ch = -1;
            if (!dbg_en)
                for (int k = 0; k < NC; k++) begin
                    int c = (mrr + k) % NC;
                    if (e_ch < 0 && ch_req[c] && !m_cack[c]) e_ch = c;
                end
            if (e_dbg) begin
                a = dbg_addr[3:0];
                if (dbg_we) shadow[a] = dbg_wdata;
                else begin exp_drd = shadow[a]; d_known = 1'b1; end
            end
            if (e_ch >= 0) begin
                mrr = (e_ch + 1) % NC;
                a = ch_addr[e_ch*AW +: 4];
                if (ch_we[e_ch]) begin
                    for (int b = 0; b < 4; b++)
                        if (ch_be[e_ch*4 + b]) shadow[a][8*b +: 8] = ch_wdata[e_ch*DW + 8*b +: 8];
                end else begin
                    exp_crd = shadow[a];
                    c_known = 1'b1;
                end
            end
            exp_hold = dbg_en;
            tick();
            exp_cack = '0;
            if (e_ch >= 0) exp_cack[e_ch] = 1'b1;
            m_dack = e_dbg;
            m_cack = exp_cack;
            checks++;
            if (dbg_ack !== m_dack || ch_ack !== m_cack || cpu_hold !== exp_hold) begin
                failures++;
                $display("FAIL rand_ack_%0d: dbg_ack=%b ch_ack=%b hold=%b want %b %b %b",
                         cyc, dbg_ack, ch_ack, cpu_hold, m_dack, m_cack, exp_hold);
            end
            if (d_known) begin
                checks++;
                if (dbg_rdata !== exp_drd) begin
                    failures++;
                    $display("FAIL rand_dbg_rdata_%0d: got %h want %h", cyc, dbg_rdata, exp_drd);
                end
            end
            if (c_known) begin
                checks++;
                if (ch_rdata !== exp_crd) begin
                    failures++;
                    $display("FAIL rand_ch_rdata_%0d: got %h want %h", cyc, ch_rdata, exp_crd);
                end
            end
            if (m_dack) dbg_req = 1'b0;
            if (!dbg_req && $urandom_range(2) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(1));
                dbg_addr = AW'($urandom_range(15)); dbg_wdata = $urandom;
            end
            for (int c = 0; c < NC; c++) begin
                if (m_cack[c]) ch_req[c] = 1'b0;
                if (!ch_req[c] && $urandom_range(2) != 0) begin
                    ch_req[c] = 1'b1; ch_we[c] = 1'($urandom_range(1));
                    ch_addr[c*AW +: AW] = AW'($urandom_range(15));
                    ch_wdata[c*DW +: DW] = $urandom;
                    ch_be[c*4 +: 4] = 4'($urandom_range(15));
                end
            end
            if ($urandom_range(15) == 0) dbg_en = ~dbg_en;
        end
        dbg_req = 1'b0; ch_req = '0; dbg_en = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_dbg_ignored();
        test_round_robin();
        test_debug_prog();
        test_byte_enable();
        test_preempt();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
